// File: rtl/dnn_pkg.sv
// Shared types and arithmetic helpers for the dense-layer engine.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } state_t;

    // Accumulator wide enough for COL_NUM full-scale products plus the bias.
    function automatic int acc_width(input int data_width, input int col_num);
        return 2 * data_width + $clog2(col_num) + 1;
    endfunction

    function automatic longint sat_to_data(input longint value, input int data_width);
        longint max_v;
        longint min_v;
        max_v = (longint'(1) <<< (data_width - 1)) - 1;
        min_v = -max_v - 1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/dnn_requant.sv
// Requantisation: floor shift, optional ReLU, saturation to the data width.
module dnn_requant
    import dnn_pkg::*;
#(
    parameter int ACC_WIDTH   = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [ACC_WIDTH-1:0]   acc,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          relu,
    output logic signed [DATA_WIDTH-1:0]  data
);

    logic signed [ACC_WIDTH-1:0] shifted;
    longint                      sat_value;

    // Oversized shifts collapse to 0 or -1 through sign fill of >>>.
    always_comb begin
        shifted = acc >>> shift;
        if (relu && (shifted < 0)) begin
            shifted = '0;
        end
        sat_value = sat_to_data(longint'(shifted), DATA_WIDTH);
        data      = sat_value[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/dnn_dense_layer.sv
// Dense layer engine: y[r] = requant(bias[r] + sum_c W[r][c]*x[c]), LANES MACs per cycle.
module dnn_dense_layer
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_NUM     = 8,
    parameter int COL_NUM     = 8,
    parameter int LANES       = 4,
    parameter int SHIFT_WIDTH = 5,
    localparam int ROW_W      = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           en,
    input  logic                           input_iv,
    output logic                           input_or,
    input  logic [DATA_WIDTH*COL_NUM-1:0]  input_id,
    input  logic                           weight_iwe,
    input  logic [ROW_W-1:0]               weight_iaddr,
    input  logic [DATA_WIDTH*COL_NUM-1:0]  weight_id,
    input  logic [DATA_WIDTH-1:0]          bias_id,
    input  logic                           relu_i,
    input  logic [SHIFT_WIDTH-1:0]         shift_i,
    output logic                           output_ov,
    input  logic                           output_ir,
    output logic signed [DATA_WIDTH-1:0]   output_od,
    output logic [ROW_W-1:0]               output_oidx,
    output logic                           output_olast,
    output logic                           busy_o
);

    localparam int ACC_W = acc_width(DATA_WIDTH, COL_NUM);
    localparam int K     = COL_NUM / LANES;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;

    state_t state_reg, state_next;

    logic [ROW_W-1:0]              row_reg;
    logic [K_W-1:0]                lane_reg;
    logic signed [ACC_W-1:0]       acc_reg;
    logic signed [ACC_W-1:0]       lane_sum;
    logic signed [ACC_W-1:0]       acc_sum;
    logic                          relu_reg;
    logic [SHIFT_WIDTH-1:0]        shift_reg;
    logic signed [DATA_WIDTH-1:0]  x_reg      [K][LANES];
    logic signed [DATA_WIDTH-1:0]  weight_mem [ROW_NUM][K][LANES];
    logic signed [DATA_WIDTH-1:0]  bias_mem   [ROW_NUM];
    logic signed [2*DATA_WIDTH-1:0] lane_prod [LANES];
    logic signed [DATA_WIDTH-1:0]  requant_data;
    logic signed [DATA_WIDTH-1:0]  bias_first;
    logic in_fire, out_fire, wr_ok, lane_last, row_last;

    assign input_or  = en && nrst && (state_reg == IDLE);
    assign in_fire   = input_iv && input_or;
    assign output_ov = (state_reg == EMIT);
    assign busy_o    = (state_reg != IDLE);
    assign out_fire  = en && output_ov && output_ir;
    assign wr_ok     = en && (state_reg == IDLE) && weight_iwe && (int'(weight_iaddr) < ROW_NUM);
    assign lane_last = (lane_reg == K_W'(K - 1));
    assign row_last  = (row_reg == ROW_W'(ROW_NUM - 1));

    // A row-0 write in the handshake cycle must already feed the first bias load.
    assign bias_first = (wr_ok && (weight_iaddr == '0)) ? $signed(bias_id) : bias_mem[0];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_prod[gi] = (2*DATA_WIDTH)'(weight_mem[row_reg][lane_reg][gi])
                                 * (2*DATA_WIDTH)'(x_reg[lane_reg][gi]);
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + ACC_W'(lane_prod[j]);
        end
        acc_sum = acc_reg + lane_sum;
    end

    dnn_requant #(
        .ACC_WIDTH   (ACC_W),
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc   (acc_sum),
        .shift (shift_reg),
        .relu  (relu_reg),
        .data  (requant_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
        end else if (en) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_fire) state_next = CALC;
            CALC: if (lane_last) state_next = EMIT;
            EMIT: if (out_fire) state_next = row_last ? IDLE : CALC;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_reg      <= '0;
            lane_reg     <= '0;
            acc_reg      <= '0;
            relu_reg     <= 1'b0;
            shift_reg    <= '0;
            output_od    <= '0;
            output_oidx  <= '0;
            output_olast <= 1'b0;
            for (int r = 0; r < ROW_NUM; r++) begin
                bias_mem[r] <= '0;
                for (int k = 0; k < K; k++) begin
                    for (int j = 0; j < LANES; j++) begin
                        weight_mem[r][k][j] <= '0;
                    end
                end
            end
            for (int k = 0; k < K; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    x_reg[k][j] <= '0;
                end
            end
        end else if (en) begin
            if (wr_ok) begin
                for (int k = 0; k < K; k++) begin
                    for (int j = 0; j < LANES; j++) begin
                        weight_mem[weight_iaddr][k][j] <= weight_id[(k*LANES+j)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                bias_mem[weight_iaddr] <= bias_id;
            end
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        for (int k = 0; k < K; k++) begin
                            for (int j = 0; j < LANES; j++) begin
                                x_reg[k][j] <= input_id[(k*LANES+j)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                        relu_reg  <= relu_i;
                        shift_reg <= shift_i;
                        row_reg   <= '0;
                        lane_reg  <= '0;
                        acc_reg   <= ACC_W'(bias_first);
                    end
                end
                CALC: begin
                    acc_reg <= acc_sum;
                    if (lane_last) begin
                        lane_reg     <= '0;
                        output_od    <= requant_data;
                        output_oidx  <= row_reg;
                        output_olast <= row_last;
                    end else begin
                        lane_reg <= lane_reg + K_W'(1);
                    end
                end
                EMIT: begin
                    if (output_ir && !row_last) begin
                        row_reg  <= row_reg + ROW_W'(1);
                        acc_reg  <= ACC_W'(bias_mem[row_reg + ROW_W'(1)]);
                        lane_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_dense_layer.sv
// Directed bench for dnn_dense_layer with hand-computed expected results.
module tb_dnn_dense_layer;

    localparam int DW = 8;
    localparam int RN = 8;
    localparam int CN = 8;
    localparam int SW = 5;

    typedef int vec_t [8];

    logic                  clk = 1'b0;
    logic                  nrst = 1'b0;
    logic                  en = 1'b1;
    logic                  input_iv = 1'b0;
    logic                  input_or;
    logic [DW*CN-1:0]      input_id = '0;
    logic                  weight_iwe = 1'b0;
    logic [2:0]            weight_iaddr = '0;
    logic [DW*CN-1:0]      weight_id = '0;
    logic [DW-1:0]         bias_id = '0;
    logic                  relu_i = 1'b0;
    logic [SW-1:0]         shift_i = '0;
    logic                  output_ov;
    logic                  output_ir = 1'b1;
    logic signed [DW-1:0]  output_od;
    logic [2:0]            output_oidx;
    logic                  output_olast;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dnn_dense_layer #(
        .DATA_WIDTH (DW),
        .ROW_NUM    (RN),
        .COL_NUM    (CN),
        .LANES      (4),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .input_iv     (input_iv),
        .input_or     (input_or),
        .input_id     (input_id),
        .weight_iwe   (weight_iwe),
        .weight_iaddr (weight_iaddr),
        .weight_id    (weight_id),
        .bias_id      (bias_id),
        .relu_i       (relu_i),
        .shift_i      (shift_i),
        .output_ov    (output_ov),
        .output_ir    (output_ir),
        .output_od    (output_od),
        .output_oidx  (output_oidx),
        .output_olast (output_olast),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*CN-1:0] pack(input vec_t v);
        logic [DW*CN-1:0] p;
        for (int c = 0; c < CN; c++) p[c*DW +: DW] = 8'(v[c]);
        return p;
    endfunction

    task automatic write_row(input int addr, input vec_t w, input int b);
        @(negedge clk);
        weight_iwe   = 1'b1;
        weight_iaddr = 3'(addr);
        weight_id    = pack(w);
        bias_id      = 8'(b);
        @(negedge clk);
        weight_iwe = 1'b0;
    endtask

    // Returns on the first falling edge after the input handshake.
    task automatic send_vector(input vec_t x, input logic relu, input int sh);
        @(negedge clk);
        input_id = pack(x);
        relu_i   = relu;
        shift_i  = 5'(sh);
        input_iv = 1'b1;
        check("input_ready", input_or, 1);
        @(negedge clk);
        input_iv = 1'b0;
        check("busy_after_accept", busy_o, 1);
    endtask

    task automatic collect(input vec_t exp, input int nrows, input int lat_start,
                           input int exp_lat, input int stall_row);
        int cnt;
        int wait_n;
        cnt = lat_start;
        for (int r = 0; r < nrows; r++) begin
            wait_n = 0;
            while (!output_ov && wait_n < 50) begin
                @(negedge clk);
                cnt++;
                wait_n++;
            end
            if (!output_ov) begin
                check("output_valid_timeout", 0, 1);
                return;
            end
            if (r == 0 && exp_lat > 0) check("first_latency", cnt, exp_lat);
            if (r == stall_row) begin
                output_ir = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_hold", {output_ov, output_od, output_oidx},
                          {1'b1, 8'(exp[r]), 3'(r)});
                end
                output_ir = 1'b1;
            end
            check($sformatf("od_row%0d", r), output_od, exp[r]);
            check($sformatf("oidx_row%0d", r), output_oidx, r);
            check($sformatf("olast_row%0d", r), output_olast, (r == RN - 1) ? 1 : 0);
            @(negedge clk);
            cnt = 0;
        end
        if (nrows == RN) begin
            repeat (3) @(negedge clk);
            check("idle_after_vector_busy", busy_o, 0);
            check("no_extra_row", output_ov, 0);
        end
    endtask

    initial begin
        vec_t w, x, e;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ov", output_ov, 0);
        check("rst_od", output_od, 0);
        check("rst_oidx", output_oidx, 0);
        check("rst_olast", output_olast, 0);
        check("rst_busy", busy_o, 0);
        check("rst_input_or", input_or, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_input_or", input_or, 1);

        // Identity weights, x = 1..8
        for (int r = 0; r < RN; r++) begin
            for (int c = 0; c < CN; c++) w[c] = (r == c) ? 1 : 0;
            write_row(r, w, 0);
        end
        x = '{1, 2, 3, 4, 5, 6, 7, 8};
        e = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_vector(x, 1'b0, 0);
        collect(e, RN, 1, 3, -1);

        // Same vector with a 10-cycle stall on row 3
        send_vector(x, 1'b0, 0);
        collect(e, RN, 1, 3, 3);

        // Positive and negative saturation
        w = '{127, 127, 127, 127, 127, 127, 127, 127};
        for (int r = 0; r < RN; r++) write_row(r, w, 127);
        send_vector(w, 1'b0, 0);
        e = '{127, 127, 127, 127, 127, 127, 127, 127};
        collect(e, RN, 1, 3, -1);
        x = '{-128, -128, -128, -128, -128, -128, -128, -128};
        send_vector(x, 1'b0, 0);
        e = '{-128, -128, -128, -128, -128, -128, -128, -128};
        collect(e, RN, 1, 3, -1);

        // Row 0 of -1s; other rows stay at 127 and saturate high
        w = '{-1, -1, -1, -1, -1, -1, -1, -1};
        write_row(0, w, 0);
        x = '{5, 5, 5, 5, 5, 5, 5, 5};
        send_vector(x, 1'b1, 0);
        e = '{0, 127, 127, 127, 127, 127, 127, 127};
        collect(e, RN, 1, 3, -1);
        send_vector(x, 1'b0, 0);
        e = '{-40, 127, 127, 127, 127, 127, 127, 127};
        collect(e, RN, 1, 3, -1);
        send_vector(x, 1'b0, 3);
        e = '{-5, 127, 127, 127, 127, 127, 127, 127};
        collect(e, RN, 1, 3, -1);

        // en low for 5 cycles in CALC, then a weight write while busy
        send_vector(x, 1'b0, 0);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("en_low_busy_frozen", busy_o, 1);
        check("en_low_no_valid", output_ov, 0);
        en           = 1'b1;
        weight_iwe   = 1'b1;
        weight_iaddr = 3'd1;
        weight_id    = '0;
        bias_id      = '0;
        @(negedge clk);
        weight_iwe = 1'b0;
        e = '{-40, 127, 127, 127, 127, 127, 127, 127};
        collect(e, RN, 7, 8, -1);
        send_vector(x, 1'b0, 0);
        collect(e, RN, 1, 3, -1);

        // en low in IDLE drops ready
        en = 1'b0;
        @(negedge clk);
        check("en_low_input_or", input_or, 0);
        en = 1'b1;

        // Reset during row 3 computation
        send_vector(x, 1'b0, 0);
        collect(e, 3, 1, 3, -1);
        #2 nrst = 1'b0;
        #1;
        check("midrst_ov", output_ov, 0);
        check("midrst_od", output_od, 0);
        check("midrst_oidx", output_oidx, 0);
        check("midrst_olast", output_olast, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_input_or", input_or, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("after_rst_busy", busy_o, 0);
        check("after_rst_input_or", input_or, 1);
        x = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_vector(x, 1'b0, 0);
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        collect(e, RN, 1, 3, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
